// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI3 slave RAM model with independent single-burst write and read channels
module axi_mem_responder #(
   parameter logic [31:0] BASE      = 32'h2000_0000,
   parameter int          MEM_WORDS = 4096,
   parameter int          ID_W      = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            s_axi_awvalid,
   output logic            s_axi_awready,
   input  logic [31:0]     s_axi_awaddr,
   input  logic [3:0]      s_axi_awlen,
   input  logic [2:0]      s_axi_awsize,
   input  logic [1:0]      s_axi_awburst,
   input  logic [ID_W-1:0] s_axi_awid,
   input  logic            s_axi_wvalid,
   output logic            s_axi_wready,
   input  logic [31:0]     s_axi_wdata,
   input  logic [3:0]      s_axi_wstrb,
   input  logic            s_axi_wlast,
   input  logic [ID_W-1:0] s_axi_wid,
   output logic            s_axi_bvalid,
   input  logic            s_axi_bready,
   output logic [1:0]      s_axi_bresp,
   output logic [ID_W-1:0] s_axi_bid,
   input  logic            s_axi_arvalid,
   output logic            s_axi_arready,
   input  logic [31:0]     s_axi_araddr,
   input  logic [3:0]      s_axi_arlen,
   input  logic [2:0]      s_axi_arsize,
   input  logic [1:0]      s_axi_arburst,
   input  logic [ID_W-1:0] s_axi_arid,
   output logic            s_axi_rvalid,
   input  logic            s_axi_rready,
   output logic [31:0]     s_axi_rdata,
   output logic [1:0]      s_axi_rresp,
   output logic            s_axi_rlast,
   output logic [ID_W-1:0] s_axi_rid
);
   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> 2) < 32'(MEM_WORDS));
   endfunction
   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return AW'((a - BASE) >> 2);
   endfunction
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
      return (b == 2'b00) ? a : a + 32'd4;
   endfunction
   logic [31:0]     mem [MEM_WORDS];
   w_state_t        w_state, w_next;
   logic [31:0]     w_addr;
   logic [3:0]      w_len, w_cnt;
   logic [1:0]      w_burst;
   logic [ID_W-1:0] w_id;
   logic            w_dec, w_slv, aw_hs, w_hs, w_end;
   r_state_t        r_state, r_next;
   logic [31:0]     r_addr, r_data;
   logic [3:0]      r_len, r_cnt;
   logic [1:0]      r_burst, r_resp;
   logic [ID_W-1:0] r_id;
   logic            r_slv, ar_hs, r_hs, r_fetch;
   logic            unused;
   assign unused  = ^s_axi_wid;
   assign aw_hs   = s_axi_awvalid && s_axi_awready;
   assign w_hs    = s_axi_wvalid && s_axi_wready;
   assign w_end   = s_axi_wlast || (w_cnt == w_len);
   assign ar_hs   = s_axi_arvalid && s_axi_arready;
   assign r_hs    = s_axi_rvalid && s_axi_rready;
   assign r_fetch = (r_state == R_FETCH) || (r_hs && !s_axi_rlast);
   // write FSM state register
   always_ff @(posedge clk_i)
      w_state <= rst_i ? W_IDLE : w_next;
   // write FSM next state: one burst at a time, response after the closing beat
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_end) w_next = W_RESP;
         W_RESP:  if (s_axi_bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end
   // write channel outputs, all forced low while reset is asserted
   always_comb begin
      s_axi_awready = !rst_i && (w_state == W_IDLE);
      s_axi_wready  = !rst_i && (w_state == W_DATA);
      s_axi_bvalid  = !rst_i && (w_state == W_RESP);
      s_axi_bresp   = s_axi_bvalid ? {w_dec || w_slv, w_dec} : 2'b00;
      s_axi_bid     = s_axi_bvalid ? w_id : '0;
   end
   // write burst context; error flags accumulate so DECERR outranks SLVERR
   always_ff @(posedge clk_i)
      if (rst_i) begin
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_burst <= '0;
         w_id    <= '0;
         w_dec   <= 1'b0;
         w_slv   <= 1'b0;
      end else if (aw_hs) begin
         w_addr  <= s_axi_awaddr;
         w_len   <= s_axi_awlen;
         w_cnt   <= '0;
         w_burst <= s_axi_awburst;
         w_id    <= s_axi_awid;
         w_dec   <= 1'b0;
         w_slv   <= (s_axi_awsize != 3'b010) || s_axi_awburst[1];
      end else if (w_hs) begin
         w_addr  <= next_addr(w_addr, w_burst);
         w_cnt   <= w_cnt + 4'd1;
         w_dec   <= w_dec || !in_range(w_addr);
         w_slv   <= w_slv || (s_axi_wlast != (w_cnt == w_len));
      end
   // byte-strobed RAM write; out-of-window beats are dropped
   always_ff @(posedge clk_i)
      if (w_hs && in_range(w_addr))
         for (int b = 0; b < 4; b++)
            if (s_axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
   // read FSM state register
   always_ff @(posedge clk_i)
      r_state <= rst_i ? R_IDLE : r_next;
   // read FSM next state: one fetch cycle before the first beat
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_FETCH;
         R_FETCH: r_next = R_DATA;
         R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end
   // read channel outputs, zero whenever no beat is presented
   always_comb begin
      s_axi_arready = !rst_i && (r_state == R_IDLE);
      s_axi_rvalid  = !rst_i && (r_state == R_DATA);
      s_axi_rlast   = s_axi_rvalid && (r_cnt == r_len);
      s_axi_rdata   = s_axi_rvalid ? r_data : '0;
      s_axi_rresp   = s_axi_rvalid ? r_resp : 2'b00;
      s_axi_rid     = s_axi_rvalid ? r_id : '0;
   end
   // read burst context and registered RAM read (read-first against same-edge writes)
   always_ff @(posedge clk_i)
      if (rst_i) begin
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_burst <= '0;
         r_id    <= '0;
         r_slv   <= 1'b0;
         r_data  <= '0;
         r_resp  <= 2'b00;
      end else if (ar_hs) begin
         r_addr  <= s_axi_araddr;
         r_len   <= s_axi_arlen;
         r_cnt   <= '0;
         r_burst <= s_axi_arburst;
         r_id    <= s_axi_arid;
         r_slv   <= (s_axi_arsize != 3'b010) || s_axi_arburst[1];
      end else if (r_fetch) begin
         r_data  <= in_range(r_addr) ? mem[word_idx(r_addr)] : '0;
         r_resp  <= !in_range(r_addr) ? 2'b11 : r_slv ? 2'b10 : 2'b00;
         r_addr  <= next_addr(r_addr, r_burst);
         r_cnt   <= r_cnt + ((r_state == R_DATA) ? 4'd1 : 4'd0);
      end
endmodule
